// File: rtl/branch_resolve_tracker_pkg.sv
// branch_resolve_tracker_pkg: shared predictor constants and tracking-entry layout
package branch_resolve_tracker_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } pred_state_e;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_PC_W  = 8;

    localparam int ENTRY_PRED_BIT = 0;
    localparam int ENTRY_PC_LSB   = 1;

endpackage

// File: rtl/branch_track_fifo.sv
// branch_track_fifo: synchronous in-order FIFO with clear and head-data output
module branch_track_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic          full;

    // occupancy flags and qualified push/pop
    always_comb begin
        empty   = count == '0;
        full    = count == (AW+1)'(DEPTH);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    // pointers wrap naturally at log2(DEPTH) bits; clear discards everything
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // entry storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker: tracks in-flight predictions, trains predictor, flags mispredicts
module branch_resolve_tracker
    import branch_resolve_tracker_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PC_W  = DEFAULT_PC_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             request,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             prediction,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             result,
    output logic             taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  flush_pc,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + 1;

    logic            req_d;
    logic [PC_W-1:0] pc_d;
    logic [EW-1:0]   head;
    logic [EW-1:0]   entry;
    logic [AW:0]     count;
    logic [AW+1:0]   pending;
    logic            fifo_empty;
    logic            pop;
    logic            flush;
    logic            push;

    branch_track_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (entry),
        .dout  (head),
        .count (count),
        .empty (fifo_empty)
    );

    // pending capture counts toward full so a request always has a slot
    always_comb begin
        pending = {1'b0, count} + (AW+2)'(req_d);
        full    = pending >= (AW+2)'(DEPTH);
        empty   = fifo_empty;
        pop     = resolve_valid && !fifo_empty;
        flush   = pop && (resolve_taken != head[ENTRY_PRED_BIT]);
        push    = req_d && !flush;
        entry   = {pc_d, prediction};
    end

    // request stage: the predictor answers one cycle after the lookup
    always_ff @(posedge clk) begin
        if (reset) begin
            req_d <= 1'b0;
            pc_d  <= '0;
        end else begin
            req_d <= request && !full;
            pc_d  <= pc_in;
        end
    end

    // registered training strobe, flush pulse and saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            result         <= 1'b0;
            taken          <= 1'b0;
            mispredict     <= 1'b0;
            flush_pc       <= '0;
            correct_cnt    <= '0;
            mispredict_cnt <= '0;
        end else begin
            result     <= pop;
            taken      <= pop && resolve_taken;
            mispredict <= flush;
            if (flush) flush_pc <= head[ENTRY_PC_LSB +: PC_W];
            if (flush && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + 1'b1;
            if (pop && !flush && !(&correct_cnt)) correct_cnt <= correct_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb_branch_resolve_tracker: randomized and directed checks against a queue-based model
module tb_branch_resolve_tracker;
    localparam int DEPTH = 4;
    localparam int PC_W  = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             request = 1'b0;
    logic [PC_W-1:0]  pc_in = '0;
    logic             prediction = 1'b0;
    logic             resolve_valid = 1'b0;
    logic             resolve_taken = 1'b0;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic [PC_W-1:0]  flush_pc;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] correct_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    branch_resolve_tracker #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .request        (request),
        .pc_in          (pc_in),
        .prediction     (prediction),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .result         (result),
        .taken          (taken),
        .mispredict     (mispredict),
        .flush_pc       (flush_pc),
        .full           (full),
        .empty          (empty),
        .correct_cnt    (correct_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } ent_t;

    ent_t            q[$];
    bit              mreq;
    logic [PC_W-1:0] mpc;
    int              m_corr;
    int              m_mis;
    logic            e_result;
    logic            e_taken;
    logic            e_mis;
    logic [PC_W-1:0] e_flush;
    int              vectors;
    int              errors;

    function automatic logic m_full();
        return (q.size() + int'(mreq)) >= DEPTH;
    endfunction

    function automatic logic m_empty();
        return q.size() == 0;
    endfunction

    task automatic step(input logic req, input logic [PC_W-1:0] pc, input logic pred,
                        input logic rv, input logic rt);
        logic pre_full;
        logic pop;
        logic mis;
        ent_t e;
        request = req;
        pc_in = pc;
        prediction = pred;
        resolve_valid = rv;
        resolve_taken = rt;
        pre_full = m_full();
        @(posedge clk);
        if (reset) begin
            q.delete();
            mreq = 0;
            mpc = '0;
            m_corr = 0;
            m_mis = 0;
            e_result = 0;
            e_taken = 0;
            e_mis = 0;
            e_flush = '0;
        end else begin
            pop = rv && (q.size() > 0);
            mis = pop && (rt != q[0].pred);
            e_result = pop;
            e_taken = pop && rt;
            e_mis = mis;
            if (mis) begin
                e_flush = q[0].pc;
                if (m_mis < CMAX) m_mis++;
            end else if (pop && m_corr < CMAX) m_corr++;
            if (pop) void'(q.pop_front());
            if (mis) q.delete();
            else if (mreq) begin
                e.pc = mpc;
                e.pred = pred;
                q.push_back(e);
            end
            mreq = req && !pre_full;
            mpc = pc;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        vectors += 6;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        if (result !== 1'b0) begin errors++; $display("FAIL reset_result: got %b want 0", result); end
        if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
        if (correct_cnt !== 8'd0) begin errors++; $display("FAIL reset_correct_cnt: got %0d want 0", correct_cnt); end
        if (mispredict_cnt !== 8'd0) begin errors++; $display("FAIL reset_mispredict_cnt: got %0d want 0", mispredict_cnt); end
        step(0, 0, 0, 1, 1);
        vectors += 2;
        if (result !== 1'b0) begin errors++; $display("FAIL idle_resolve_result: got %b want 0", result); end
        if (correct_cnt !== 8'd0) begin errors++; $display("FAIL idle_resolve_cnt: got %0d want 0", correct_cnt); end
    endtask

    task automatic test_correct();
        step(1, 8'h10, 0, 0, 0);
        vectors += 1;
        if (empty !== 1'b1) begin errors++; $display("FAIL capture_latency_empty: got %b want 1", empty); end
        step(0, 8'h00, 1, 0, 0);
        vectors += 1;
        if (empty !== 1'b0) begin errors++; $display("FAIL capture_visible: got empty=%b want 0", empty); end
        step(0, 8'h00, 0, 1, 1);
        vectors += 5;
        if (result !== 1'b1) begin errors++; $display("FAIL correct_result: got %b want 1", result); end
        if (taken !== 1'b1) begin errors++; $display("FAIL correct_taken: got %b want 1", taken); end
        if (mispredict !== 1'b0) begin errors++; $display("FAIL correct_mispredict: got %b want 0", mispredict); end
        if (correct_cnt !== 8'd1) begin errors++; $display("FAIL correct_cnt: got %0d want 1", correct_cnt); end
        if (empty !== 1'b1) begin errors++; $display("FAIL correct_empty: got %b want 1", empty); end
        step(0, 0, 0, 0, 0);
        vectors += 1;
        if (result !== 1'b0) begin errors++; $display("FAIL result_strobe: got %b want 0", result); end
    endtask

    task automatic test_mispredict();
        step(1, 8'h20, 0, 0, 0);
        step(1, 8'h21, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 1);
        vectors += 5;
        if (mispredict !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", mispredict); end
        if (flush_pc !== 8'h20) begin errors++; $display("FAIL mis_flush_pc: got %h want 20", flush_pc); end
        if (mispredict_cnt !== 8'd1) begin errors++; $display("FAIL mis_cnt: got %0d want 1", mispredict_cnt); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mis_flush_empty: got %b want 1", empty); end
        if (taken !== 1'b1) begin errors++; $display("FAIL mis_taken: got %b want 1", taken); end
        step(0, 8'h00, 0, 1, 1);
        vectors += 2;
        if (result !== 1'b0) begin errors++; $display("FAIL post_flush_result: got %b want 0", result); end
        if (mispredict !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", mispredict); end
    endtask

    task automatic test_full();
        logic [CNT_W-1:0] want;
        want = CNT_W'(m_corr + 4);
        for (int i = 0; i < 4; i++) step(1, 8'h30 + PC_W'(i), 1, 0, 0);
        vectors += 1;
        if (full !== 1'b1) begin errors++; $display("FAIL full_after_4: got %b want 1", full); end
        step(1, 8'h34, 1, 0, 0);
        vectors += 2;
        if (full !== 1'b1) begin errors++; $display("FAIL full_held: got %b want 1", full); end
        if (q.size() != 4 || mreq) begin errors++; $display("FAIL full_model_occupancy: got %0d want 4", q.size()); end
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1);
            vectors += 1;
            if (result !== 1'b1) begin errors++; $display("FAIL full_drain_result %0d: got %b want 1", i, result); end
        end
        vectors += 3;
        if (correct_cnt !== want) begin errors++; $display("FAIL full_drain_cnt: got %0d want %0d", correct_cnt, want); end
        if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b want 1", empty); end
        step(0, 0, 0, 1, 1);
        if (result !== 1'b0) begin errors++; $display("FAIL fifth_ignored: got result=%b want 0", result); end
    endtask

    task automatic test_back_to_back();
        step(1, 8'h40, 0, 0, 0);
        step(1, 8'h41, 0, 0, 0);
        step(1, 8'h42, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        vectors += 4;
        if (result !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL b2b_pop: got result=%b mis=%b want 1 0", result, mispredict); end
        if (q.size() != 2) begin errors++; $display("FAIL b2b_model_occupancy: got %0d want 2", q.size()); end
        if (empty !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", full); end
        step(0, 8'h00, 0, 1, 1);
        vectors += 2;
        if (mispredict !== 1'b1) begin errors++; $display("FAIL b2b_order_mis: got %b want 1", mispredict); end
        if (flush_pc !== 8'h41) begin errors++; $display("FAIL b2b_order_pc: got %h want 41", flush_pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            step(logic'($urandom_range(0, 2) != 0), PC_W'($urandom), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) != 0));
            reset = 1'b0;
            vectors += 1;
            if (result !== e_result || taken !== e_taken || mispredict !== e_mis ||
                flush_pc !== e_flush || full !== m_full() || empty !== m_empty() ||
                correct_cnt !== CNT_W'(m_corr) || mispredict_cnt !== CNT_W'(m_mis)) begin
                errors++;
                $display("FAIL random %0d: got r%b t%b m%b pc%h f%b e%b c%0d x%0d want r%b t%b m%b pc%h f%b e%b c%0d x%0d",
                         i, result, taken, mispredict, flush_pc, full, empty, correct_cnt, mispredict_cnt,
                         e_result, e_taken, e_mis, e_flush, m_full(), m_empty(), m_corr, m_mis);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            step(1, PC_W'(i), 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 1);
        end
        vectors += 2;
        if (mispredict_cnt !== 8'hFF) begin errors++; $display("FAIL mis_saturate: got %0d want 255", mispredict_cnt); end
        if (mispredict !== 1'b1) begin errors++; $display("FAIL mis_saturate_pulse: got %b want 1", mispredict); end
        step(1, 8'h50, 1, 0, 0);
        step(1, 8'h51, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        vectors += 1;
        if (empty !== 1'b0) begin errors++; $display("FAIL midstream_inflight: got empty=%b want 0", empty); end
        reset = 1'b1;
        step(1, 8'h52, 1, 1, 1);
        reset = 1'b0;
        vectors += 4;
        if (empty !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %b want 1", empty); end
        if (correct_cnt !== 8'd0) begin errors++; $display("FAIL midreset_correct: got %0d want 0", correct_cnt); end
        if (mispredict_cnt !== 8'd0) begin errors++; $display("FAIL midreset_mis: got %0d want 0", mispredict_cnt); end
        if (flush_pc !== 8'h00) begin errors++; $display("FAIL midreset_flush_pc: got %h want 00", flush_pc); end
        step(0, 0, 0, 1, 1);
        vectors += 1;
        if (result !== 1'b0) begin errors++; $display("FAIL midreset_discard: got result=%b want 0", result); end
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        q.delete();
        mreq = 0;
        mpc = '0;
        m_corr = 0;
        m_mis = 0;
        test_reset();
        test_correct();
        test_mispredict();
        test_full();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
